// File: rtl/pipe_adder.sv
// Carry-chunked pipelined adder: stage k adds bits [k*CHUNK +: CHUNK] with the carry from stage k-1.
// Define PIPE_ADDER_SAT_EN to add the per-beat `sat` input for unsigned saturation.
module pipe_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PIPE_ADDER_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;

  if ((WIDTH % CHUNK) != 0 || STAGES < 1) begin : g_bad_params
    $error("pipe_adder: WIDTH must be a non-zero multiple of CHUNK");
  end

  // Each stage carries the full operands and the partial sum; untouched slices prune away.
  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] carry_q, carry_d;
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  b_d   [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
`ifdef PIPE_ADDER_SAT_EN
  logic [STAGES-1:0] sat_q, sat_d;
`endif

  logic [WIDTH-1:0]  a_src   [STAGES];
  logic [WIDTH-1:0]  b_src   [STAGES];
  logic [WIDTH-1:0]  sum_src [STAGES];
  logic [STAGES-1:0] carry_src;
  logic [CHUNK:0]    part;
  logic              stall;

  assign stall    = valid_q[LAST] && !out_ready;
  assign in_ready = !stall;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    part         = '0;
    a_src[0]     = a;
    b_src[0]     = b;
    sum_src[0]   = '0;
    carry_src[0] = cin;
    valid_d[0]   = in_valid;
`ifdef PIPE_ADDER_SAT_EN
    sat_d[0]     = sat;
`endif
    for (int k = 1; k < STAGES; k++) begin
      a_src[k]     = a_q[k-1];
      b_src[k]     = b_q[k-1];
      sum_src[k]   = sum_q[k-1];
      carry_src[k] = carry_q[k-1];
      valid_d[k]   = valid_q[k-1];
`ifdef PIPE_ADDER_SAT_EN
      sat_d[k]     = sat_q[k-1];
`endif
    end
    for (int k = 0; k < STAGES; k++) begin
      part = {1'b0, a_src[k][k*CHUNK +: CHUNK]}
           + {1'b0, b_src[k][k*CHUNK +: CHUNK]}
           + (CHUNK+1)'(carry_src[k]);
      a_d[k]                     = a_src[k];
      b_d[k]                     = b_src[k];
      sum_d[k]                   = sum_src[k];
      sum_d[k][k*CHUNK +: CHUNK] = part[CHUNK-1:0];
      carry_d[k]                 = part[CHUNK];
    end
  end

  // NOTE: the datapath registers are reset too, so sum/cout/ovf read 0 rather than X after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      carry_q <= '0;
      a_q     <= '{default: '0};
      b_q     <= '{default: '0};
      sum_q   <= '{default: '0};
`ifdef PIPE_ADDER_SAT_EN
      sat_q   <= '0;
`endif
    end else if (!stall) begin
      // NOTE: non-blocking updates let every stage sample its predecessor's old value.
      valid_q <= valid_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
`ifdef PIPE_ADDER_SAT_EN
      sat_q   <= sat_d;
`endif
    end
  end

  assign out_valid = valid_q[LAST];
  assign cout      = carry_q[LAST];
  // Overflow and carry always describe the wrapped sum, even when saturating.
  assign ovf       = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1])
                  && (sum_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);
`ifdef PIPE_ADDER_SAT_EN
  assign sum       = (sat_q[LAST] && carry_q[LAST]) ? '1 : sum_q[LAST];
`else
  assign sum       = sum_q[LAST];
`endif

endmodule
